// File: rtl/systolic_ws_pkg.sv
// systolic_ws_pkg: shared state encoding and elaboration helpers for the weight-stationary tile
package systolic_ws_pkg;

  typedef enum logic [1:0] {EMPTY, LOAD, RUN, DRAIN} state_e;

  function automatic int latency(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  function automatic bit acc_width_ok(input int in_w, input int acc_w, input int rows);
    return acc_w >= 2 * in_w + $clog2(rows);
  endfunction

endpackage

// File: rtl/systolic_ws_acc_pe.sv
// systolic_ws_acc_pe: one PE holding a stationary weight, passing activations east and widened partial sums south
module systolic_ws_acc_pe #(
  parameter int IN_WIDTH    = 8,
  parameter int ACC_WIDTH   = 20,
  parameter bit SIGNED_MODE = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_i,
  input  logic                 w_ld_i,
  input  logic [IN_WIDTH-1:0]  w_i,
  input  logic [IN_WIDTH-1:0]  west_i,
  input  logic [ACC_WIDTH-1:0] north_i,
  output logic [IN_WIDTH-1:0]  east_o,
  output logic [ACC_WIDTH-1:0] south_o
);

  logic [IN_WIDTH-1:0]  w_q, east_q;
  logic [ACC_WIDTH-1:0] south_q, south_d, w_ext, a_ext;

  assign w_ext   = {{(ACC_WIDTH-IN_WIDTH){SIGNED_MODE & w_q[IN_WIDTH-1]}}, w_q};
  assign a_ext   = {{(ACC_WIDTH-IN_WIDTH){SIGNED_MODE & west_i[IN_WIDTH-1]}}, west_i};
  assign south_d = north_i + w_ext * a_ext;
  assign east_o  = east_q;
  assign south_o = south_q;

  // weight loads only while the array is idle, so it ignores the stall enable
  always_ff @(posedge clk)
    if (reset) w_q <= '0;
    else if (w_ld_i) w_q <= w_i;

  // activation and partial-sum pipeline freezes together with the rest of the array
  always_ff @(posedge clk)
    if (reset) begin
      east_q  <= '0;
      south_q <= '0;
    end else if (en_i) begin
      east_q  <= west_i;
      south_q <= south_d;
    end

endmodule

// File: rtl/systolic_ws_tile.sv
// systolic_ws_tile: weight-stationary GEMV tile with skew/de-skew, ready/valid preload and drain-before-reload FSM
// Define SYSTOLIC_WS_TILE_SIGNED_EN for two's-complement operands and results; default build is unsigned.
module systolic_ws_tile
  import systolic_ws_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 20,
  parameter int ROW_NUM   = 4,
  parameter int COL_NUM   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [COL_NUM*IN_WIDTH-1:0]  w_row,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [ROW_NUM*IN_WIDTH-1:0]  a_vec,
  output logic                         y_valid,
  input  logic                         y_ready,
  output logic [COL_NUM*ACC_WIDTH-1:0] y_vec,
  output logic                         busy
);

  localparam int LAT = latency(ROW_NUM, COL_NUM);
  localparam int CW  = $clog2(ROW_NUM + 1);
  localparam int FW  = $clog2(LAT + 1) + 1;
`ifdef SYSTOLIC_WS_TILE_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  if (!acc_width_ok(IN_WIDTH, ACC_WIDTH, ROW_NUM)) begin : g_acc_chk
    $error("ACC_WIDTH too narrow for IN_WIDTH and ROW_NUM");
  end

  state_e                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [FW-1:0]               inflight_q, inflight_d;
  logic [LAT-1:0]              vp_q;
  logic                        adv, acc, wbeat;
  logic [ROW_NUM*IN_WIDTH-1:0] a_in;
  logic [IN_WIDTH-1:0]         act  [ROW_NUM][COL_NUM+1];
  logic [ACC_WIDTH-1:0]        psum [ROW_NUM+1][COL_NUM];

  assign y_valid    = vp_q[LAT-1];
  assign adv        = ~(y_valid & ~y_ready);
  assign acc        = a_valid & a_ready;
  assign wbeat      = w_valid & w_ready;
  assign a_in       = acc ? a_vec : '0;
  assign busy       = (state_q != EMPTY) | (inflight_q != '0);
  assign inflight_d = inflight_q + FW'(acc) - FW'(y_valid & y_ready);

  // control state, row counter, in-flight count and the valid shift register
  always_ff @(posedge clk)
    if (reset) begin
      state_q    <= EMPTY;
      cnt_q      <= '0;
      inflight_q <= '0;
      vp_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      if (adv) vp_q <= (vp_q << 1) | LAT'(acc);
    end

  // a weight request during RUN only moves to DRAIN; beats are taken again once EMPTY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_ready = 1'b0;
    a_ready = 1'b0;
    case (state_q)
      EMPTY, LOAD: begin
        w_ready = 1'b1;
        if (w_valid) begin
          state_d = (cnt_q == CW'(ROW_NUM - 1)) ? RUN : LOAD;
          cnt_d   = (cnt_q == CW'(ROW_NUM - 1)) ? '0 : cnt_q + 1'b1;
        end
      end
      RUN: begin
        a_ready = adv;
        state_d = w_valid ? DRAIN : RUN;
      end
      DRAIN:   state_d = (inflight_q == '0) ? EMPTY : DRAIN;
      default: state_d = EMPTY;
    endcase
  end

  genvar i, j;
  for (i = 0; i < ROW_NUM; i++) begin : g_row
    if (i == 0) begin : g_direct
      assign act[i][0] = a_in[0 +: IN_WIDTH];
    end else begin : g_skew
      logic [IN_WIDTH-1:0] sr_q [i];
      // delay row i by i advancing cycles so the wavefront meets the partial sums
      always_ff @(posedge clk)
        if (reset) begin
          for (int k = 0; k < i; k++) sr_q[k] <= '0;
        end else if (adv) begin
          sr_q[0] <= a_in[i*IN_WIDTH +: IN_WIDTH];
          for (int k = 1; k < i; k++) sr_q[k] <= sr_q[k-1];
        end
      assign act[i][0] = sr_q[i-1];
    end
    for (j = 0; j < COL_NUM; j++) begin : g_col
      if (i == 0) begin : g_top
        assign psum[0][j] = '0;
      end
      systolic_ws_acc_pe #(
        .IN_WIDTH   (IN_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SIGNED_MODE(SGN)
      ) u_pe (
        .clk    (clk),
        .reset  (reset),
        .en_i   (adv),
        .w_ld_i (wbeat & (cnt_q == CW'(i))),
        .w_i    (w_row[j*IN_WIDTH +: IN_WIDTH]),
        .west_i (act[i][j]),
        .north_i(psum[i][j]),
        .east_o (act[i][j+1]),
        .south_o(psum[i+1][j])
      );
    end
  end

  for (j = 0; j < COL_NUM; j++) begin : g_deskew
    localparam int D = COL_NUM - 1 - j;
    if (D == 0) begin : g_direct
      assign y_vec[j*ACC_WIDTH +: ACC_WIDTH] = psum[ROW_NUM][j];
    end else begin : g_delay
      logic [ACC_WIDTH-1:0] ds_q [D];
      // hold early columns back until the last column finishes the same vector
      always_ff @(posedge clk)
        if (reset) begin
          for (int k = 0; k < D; k++) ds_q[k] <= '0;
        end else if (adv) begin
          ds_q[0] <= psum[ROW_NUM][j];
          for (int k = 1; k < D; k++) ds_q[k] <= ds_q[k-1];
        end
      assign y_vec[j*ACC_WIDTH +: ACC_WIDTH] = ds_q[D-1];
    end
  end

endmodule

// File: tb/tb_systolic_ws_tile.sv
// tb_systolic_ws_tile: scoreboard bench with a matrix-vector reference model for systolic_ws_tile
module tb_systolic_ws_tile;

  localparam int IN  = 8;
  localparam int ACC = 20;
  localparam int ROW = 4;
  localparam int COL = 4;
  localparam int LAT = ROW + COL - 1;

  typedef logic [COL*IN-1:0] row_t;
  typedef struct {
    logic [COL*ACC-1:0] y;
    int                 cyc;
    int                 stl;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset, w_valid, w_ready, a_valid, a_ready, y_valid, y_ready, busy;
  logic [COL*IN-1:0]  w_row;
  logic [ROW*IN-1:0]  a_vec;
  logic [COL*ACC-1:0] y_vec, last_y, prev_y;

  logic [IN-1:0] wm [ROW][COL];
  exp_t          q [$];
  int            n_checks = 0, n_fail = 0, n_in = 0, n_out = 0, n_drop = 0;
  int            cyc = 0, stl_cnt = 0, mrow = 0;
  bit            stall_flag = 0, prev_stall = 0, done = 0;

  systolic_ws_tile #(.IN_WIDTH(IN), .ACC_WIDTH(ACC), .ROW_NUM(ROW), .COL_NUM(COL)) dut (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
    .a_valid(a_valid), .a_ready(a_ready), .a_vec(a_vec),
    .y_valid(y_valid), .y_ready(y_ready), .y_vec(y_vec), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic longint ext(input logic [IN-1:0] x);
`ifdef SYSTOLIC_WS_TILE_SIGNED_EN
    return longint'($signed(x));
`else
    return longint'(x);
`endif
  endfunction

  function automatic logic [COL*ACC-1:0] model(input logic [ROW*IN-1:0] a);
    logic [COL*ACC-1:0] r;
    longint s;
    r = '0;
    for (int j = 0; j < COL; j++) begin
      s = 0;
      for (int i = 0; i < ROW; i++) s += ext(a[i*IN +: IN]) * ext(wm[i][j]);
      r[j*ACC +: ACC] = s[ACC-1:0];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (stall_flag) stl_cnt <= stl_cnt + 1;
  end

  // stimulus tracker: mirror accepted weight rows and push expected results
  always @(negedge clk) begin
    if (reset) begin
      mrow = 0;
      for (int i = 0; i < ROW; i++) for (int j = 0; j < COL; j++) wm[i][j] = '0;
    end else begin
      if (w_valid && w_ready) begin
        if (mrow == 0) chk("busy_at_row0", busy, 0);
        for (int j = 0; j < COL; j++) wm[mrow][j] = w_row[j*IN +: IN];
        mrow = (mrow + 1) % ROW;
      end
      if (a_valid && a_ready) begin
        q.push_back('{model(a_vec), cyc, stl_cnt});
        n_in++;
      end
    end
  end

  // output monitor: pop and compare on every result handshake
  always @(negedge clk) begin
    exp_t e;
    stall_flag = y_valid && !y_ready && !reset;
    if (reset) begin
      n_drop += q.size();
      q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_y", y_vec, prev_y);
        chk("stall_hold_v", y_valid, 1);
      end
      if (stall_flag) chk("stall_a_ready", a_ready, 0);
      if (y_valid && y_ready) begin
        chk("y_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("y_vec", y_vec, e.y);
          chk("latency", cyc - e.cyc, LAT + stl_cnt - e.stl);
          last_y = y_vec;
          n_out++;
        end
      end
      prev_stall = stall_flag;
      prev_y = y_vec;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [ROW*IN-1:0] v);
    int t;
    logic ok;
    t = 0;
    ok = 0;
    a_valid = 1;
    a_vec = v;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = a_ready;
      step();
      t++;
    end
    chk("a_accept", ok, 1);
    a_valid = 0;
  endtask

  task automatic load_w(input row_t r [ROW]);
    int t;
    logic ok;
    for (int k = 0; k < ROW; k++) begin
      t = 0;
      ok = 0;
      w_valid = 1;
      w_row = r[k];
      while (!ok && t < 300) begin
        @(negedge clk);
        ok = w_ready;
        step();
        t++;
      end
      chk("w_accept", ok, 1);
      w_valid = 0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (q.size() != 0 && t < 500) begin
      step();
      t++;
    end
    chk("drain_queue", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t r [ROW];
    reset = 1; w_valid = 0; a_valid = 0; y_ready = 1; w_row = '0; a_vec = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_vec", y_vec, 0);
    chk("rst_w_ready", w_ready, 1);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_busy", busy, 0);
    step();
    reset = 0;
    // identity weights
    for (int k = 0; k < ROW; k++) begin
      r[k] = '0;
      r[k][k*IN +: IN] = 8'd1;
    end
    load_w(r);
    send({8'd4, 8'd3, 8'd2, 8'd1});
    wait_idle();
    chk("identity_y", last_y, {20'd4, 20'd3, 20'd2, 20'd1});
    // W[i][j] = i + j, back-to-back stream
    for (int k = 0; k < ROW; k++)
      for (int j = 0; j < COL; j++) r[k][j*IN +: IN] = 8'(k + j);
    load_w(r);
    for (int k = 1; k <= 10; k++) send({4{8'(k)}});
    wait_idle();
    chk("b2b_last_y", last_y, {20'd180, 20'd140, 20'd100, 20'd60});
    // all-ones operands
    for (int k = 0; k < ROW; k++) r[k] = '1;
    load_w(r);
    send('1);
    wait_idle();
`ifdef SYSTOLIC_WS_TILE_SIGNED_EN
    chk("max_y", last_y, {4{20'd4}});
`else
    chk("max_y", last_y, {4{20'h3F804}});
`endif
    // backpressure at the first result
    for (int k = 0; k < ROW; k++) r[k] = row_t'($urandom);
    load_w(r);
    fork
      begin
        for (int k = 0; k < 10; k++) send(ROW*IN'($urandom));
      end
      begin
        int t;
        t = 0;
        while (!y_valid && t < 50) begin
          step();
          t++;
        end
        chk("bp_first_valid", y_valid, 1);
        y_ready = 0;
        repeat (5) step();
        y_ready = 1;
      end
    join
    wait_idle();
    // reload with three vectors in flight
    for (int k = 0; k < 3; k++) send(ROW*IN'($urandom));
    for (int k = 0; k < ROW; k++) r[k] = row_t'($urandom);
    w_valid = 1;
    w_row = r[0];
    @(negedge clk);
    chk("run_w_ready", w_ready, 0);
    step();
    @(negedge clk);
    chk("drain_a_ready", a_ready, 0);
    chk("drain_busy", busy, 1);
    step();
    load_w(r);
    for (int k = 0; k < 3; k++) send(ROW*IN'($urandom));
    wait_idle();
    // random traffic with random backpressure
    for (int k = 0; k < ROW; k++) r[k] = row_t'($urandom);
    load_w(r);
    done = 0;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 2)) step();
          send(ROW*IN'($urandom));
        end
        done = 1;
      end
      begin
        while (!done) begin
          y_ready = ($urandom_range(0, 3) != 0);
          step();
        end
        y_ready = 1;
      end
    join
    wait_idle();
    // reset with four vectors in flight
    for (int k = 0; k < 4; k++) send(ROW*IN'($urandom));
    reset = 1;
    step();
    reset = 0;
    repeat (12) step();
    @(negedge clk);
    chk("post_rst_w_ready", w_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_y_valid", y_valid, 0);
    step();
`ifdef SYSTOLIC_WS_TILE_SIGNED_EN
    for (int k = 0; k < ROW; k++) r[k] = {4{8'd2}};
    load_w(r);
    send({4{8'hFF}});
    wait_idle();
    chk("signed_y", last_y, {4{20'hFFFF8}});
`endif
    repeat (3) step();
    chk("io_count", n_out + n_drop, n_in);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
